// File: rtl/entrada_condicionador.sv
// Switch input conditioner: a two-flop synchronizer and a per-bit debounce counter feeding the gate-controller FSM input word.
// Optional ENTRADA_SENSOR_CHECK_EN: blocks any commit that would leave both limit sensors (aberto, fechado) high at once.
module entrada_condicionador #(
    parameter int WIDTH           = 5,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16,
    parameter int IDX_ABERTO      = 3,
    parameter int IDX_FECHADO     = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] changed,
    output logic             quieto,
    output logic             erro_sensor
);

`ifdef ENTRADA_SENSOR_CHECK_EN
    localparam bit SENSOR_CHECK = 1'b1;
`else
    localparam bit SENSOR_CHECK = 1'b0;
`endif

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [CNT_W-1:0] cnt [WIDTH];
    logic [WIDTH-1:0] differ;
    logic [WIDTH-1:0] commit_req;
    logic [WIDTH-1:0] blocked;
    logic [WIDTH-1:0] commit;
    logic [WIDTH-1:0] busy;

    logic rise_a;
    logic rise_f;
    logic blk_a;
    logic blk_f;
    logic aberto_n;
    logic fechado_n;
    logic erro_next;

    always_comb begin
        differ     = '0;
        commit_req = '0;
        busy       = '0;
        for (int i = 0; i < WIDTH; i++) begin
            differ[i]     = sync2[i] ^ sw_out[i];
            commit_req[i] = differ[i] && (cnt[i] == CNT_MAX);
            busy[i]       = (cnt[i] != '0);
        end
    end

    assign quieto = ~|busy;

    // A sensor rising to 1 is held off while the other sensor is 1 now or rises in the same cycle.
    always_comb begin
        rise_a    = commit_req[IDX_ABERTO] & sync2[IDX_ABERTO];
        rise_f    = commit_req[IDX_FECHADO] & sync2[IDX_FECHADO];
        blk_a     = SENSOR_CHECK & rise_a & (sw_out[IDX_FECHADO] | rise_f);
        blk_f     = SENSOR_CHECK & rise_f & (sw_out[IDX_ABERTO] | rise_a);
        blocked   = '0;
        blocked[IDX_ABERTO]  = blk_a;
        blocked[IDX_FECHADO] = blk_f;
        aberto_n  = sw_out[IDX_ABERTO] ^ (commit_req[IDX_ABERTO] & ~blk_a);
        fechado_n = sw_out[IDX_FECHADO] ^ (commit_req[IDX_FECHADO] & ~blk_f);
        // The flag tracks whether the conflict still exists after this edge, so it drops
        // on the same edge the opposing sensor commits to 0.
        erro_next = (blk_a & fechado_n) | (blk_f & aberto_n) | (blk_a & blk_f);
    end

    assign commit = commit_req & ~blocked;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1       <= '0;
            sync2       <= '0;
            sw_out      <= '0;
            changed     <= '0;
            erro_sensor <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1       <= sw_in;
            sync2       <= sync1;
            sw_out      <= sw_out ^ commit;
            changed     <= commit;
            erro_sensor <= erro_next;
            for (int i = 0; i < WIDTH; i++) begin
                if (!differ[i] || commit[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] != CNT_MAX) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_entrada_condicionador.sv
// Directed bench for entrada_condicionador with DEBOUNCE_CYCLES=4 (commit lands 6 edges after an input step).
module tb_entrada_condicionador;

    logic       clock;
    logic       reset_n;
    logic [4:0] sw_in;
    logic [4:0] sw_out;
    logic [4:0] changed;
    logic       quieto;
    logic       erro_sensor;

    int passed = 0;
    int total  = 0;

    entrada_condicionador #(
        .WIDTH(5), .DEBOUNCE_CYCLES(4), .CNT_W(3), .IDX_ABERTO(3), .IDX_FECHADO(2)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .sw_in(sw_in),
        .sw_out(sw_out),
        .changed(changed),
        .quieto(quieto),
        .erro_sensor(erro_sensor)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    initial begin
        // reset with all switches high
        reset_n = 1'b0;
        sw_in   = 5'b11111;
        tick(3);
        chk("rst_sw_out", sw_out, 5'b00000);
        chk("rst_changed", changed, 5'b00000);
        chk("rst_quieto", quieto, 1'b1);
        chk("rst_erro", erro_sensor, 1'b0);

        reset_n = 1'b1;
        tick(5);
        chk("rel_sw_out_e5", sw_out, 5'b00000);
        chk("rel_quieto_e5", quieto, 1'b0);
        tick(1);
        chk("rel_sw_out_e6", sw_out, 5'b11111);
        chk("rel_changed_e6", changed, 5'b11111);
        tick(1);
        chk("rel_changed_e7", changed, 5'b00000);
        chk("rel_quieto_e7", quieto, 1'b1);

        // back to zero, then clean step
        sw_in = 5'b00000;
        tick(7);
        chk("zero_sw_out", sw_out, 5'b00000);
        sw_in = 5'b10110;
        tick(2);
        chk("step_quieto_e2", quieto, 1'b1);
        tick(1);
        chk("step_quieto_e3", quieto, 1'b0);
        tick(2);
        chk("step_quieto_e5", quieto, 1'b0);
        chk("step_sw_out_e5", sw_out, 5'b00000);
        tick(1);
        chk("step_sw_out_e6", sw_out, 5'b10110);
        chk("step_changed_e6", changed, 5'b10110);
        chk("step_quieto_e6", quieto, 1'b1);
        tick(1);
        chk("step_changed_e7", changed, 5'b00000);

        sw_in = 5'b00000;
        tick(7);
        chk("zero2_sw_out", sw_out, 5'b00000);

        // glitch of 3 synchronized cycles on bit 4
        sw_in = 5'b10000;
        tick(3);
        sw_in = 5'b00000;
        tick(2);
        chk("glitch_quieto_e5", quieto, 1'b0);
        chk("glitch_sw_out_e5", sw_out, 5'b00000);
        tick(1);
        chk("glitch_quieto_e6", quieto, 1'b1);
        chk("glitch_changed_e6", changed, 5'b00000);
        tick(3);
        chk("glitch_sw_out_end", sw_out, 5'b00000);

        // bounce on bit 0: high 2, low 1, high
        sw_in = 5'b00001;
        tick(2);
        sw_in = 5'b00000;
        tick(1);
        sw_in = 5'b00001;
        tick(5);
        chk("bounce_sw_out_e8", sw_out, 5'b00000);
        tick(1);
        chk("bounce_sw_out_e9", sw_out, 5'b00001);
        chk("bounce_changed_e9", changed, 5'b00001);
        tick(2);

        // async reset with bit 3 at cnt=2
        sw_in = 5'b01001;
        tick(4);
        chk("midcnt_quieto", quieto, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_sw_out", sw_out, 5'b00000);
        chk("arst_changed", changed, 5'b00000);
        chk("arst_quieto", quieto, 1'b1);
        tick(1);
        reset_n = 1'b1;
        tick(5);
        chk("arel_sw_out_e5", sw_out, 5'b00000);
        tick(1);
        chk("arel_sw_out_e6", sw_out, 5'b01001);
        chk("arel_changed_e6", changed, 5'b01001);
        tick(1);

        // fechado rises while aberto is established
        sw_in = 5'b01101;
        tick(6);
`ifdef ENTRADA_SENSOR_CHECK_EN
        chk("conf_sw_out", sw_out, 5'b01001);
        chk("conf_erro", erro_sensor, 1'b1);
        chk("conf_changed", changed, 5'b00000);
`else
        chk("conf_sw_out", sw_out, 5'b01101);
        chk("conf_erro", erro_sensor, 1'b0);
        chk("conf_changed", changed, 5'b00100);
`endif
        sw_in = 5'b00101;
        tick(5);
`ifdef ENTRADA_SENSOR_CHECK_EN
        chk("drop_erro_e5", erro_sensor, 1'b1);
        tick(1);
        chk("drop_sw_out_e6", sw_out, 5'b00001);
        chk("drop_erro_e6", erro_sensor, 1'b0);
        tick(1);
        chk("drop_sw_out_e7", sw_out, 5'b00101);
        chk("drop_changed_e7", changed, 5'b00100);
`else
        chk("drop_sw_out_e5", sw_out, 5'b01101);
        tick(1);
        chk("drop_sw_out_e6", sw_out, 5'b00101);
        chk("drop_changed_e6", changed, 5'b01000);
        chk("drop_erro_e6", erro_sensor, 1'b0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/entrada_condicionador.md
Name: entrada_condicionador

Overview:
- Upstream input conditioner for the gate-controller state machine. It takes the raw board switch vector (botao, aberto, fechado, motor, sentido) and returns a clean, synchronized, debounced vector.
- The state machine samples this vector directly as its 5-bit input word.
- Per-bit two-flop synchronizer followed by a per-bit stability counter. Also produces per-bit change pulses and a global settled flag.

Parameters:
- WIDTH, 5, number of input bits; bit order matches the FSM input word, MSB = botao.
- DEBOUNCE_CYCLES, 50000, consecutive clock cycles a synchronized bit must differ from its output before the output updates. Must be >= 1. The default is 1 ms at 50 MHz.
- CNT_W, 16, counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES-1.
- IDX_ABERTO, 3, bit index of the "aberto" limit sensor.
- IDX_FECHADO, 2, bit index of the "fechado" limit sensor.

Ports:
- clock, input, 1, single system clock; all state on rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- sw_in, input, WIDTH, raw asynchronous switch levels.
- sw_out, output, WIDTH, debounced levels, registered.
- changed, output, WIDTH, one-cycle pulse per bit on the cycle that bit of sw_out toggles, registered.
- quieto, output, 1, high when every bit counter is 0, i.e. nothing pending.
- erro_sensor, output, 1, sensor-conflict flag; see Optional Feature.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. reset_n=0 immediately clears:
  - both synchronizer stages, sw_out, changed, all counters and erro_sensor to 0;
  - quieto goes to 1.
  - Reset mid-count discards the pending change.
- Synchronizer: sync1 <= sw_in; sync2 <= sync1. Only sync2 is used downstream.
- Per bit i, every edge:
  - sync2[i] == sw_out[i]: cnt[i] <= 0; no change.
  - sync2[i] != sw_out[i] and cnt[i] < DEBOUNCE_CYCLES-1: cnt[i] <= cnt[i]+1.
  - sync2[i] != sw_out[i] and cnt[i] == DEBOUNCE_CYCLES-1: sw_out[i] <= sync2[i]; changed[i] <= 1; cnt[i] <= 0.
  - changed[i] is 0 on every other edge.
- Latency: a clean step on sw_in[i] appears on sw_out[i] exactly 2 + DEBOUNCE_CYCLES rising edges later.
- Glitches:
  - Any disagreement lasting fewer than DEBOUNCE_CYCLES synchronized cycles resets the count and leaves sw_out unchanged.
  - A bounce back to the old value restarts counting from 0.
- DEBOUNCE_CYCLES=1: the output follows sync2 with 1 edge of delay; the counter never leaves 0.
- Bits are fully independent. Simultaneous commits on several bits in the same cycle are all applied, with multiple changed bits high together.
- quieto = NOR of all (cnt[i] != 0), combinational from registers.
- The counter never exceeds DEBOUNCE_CYCLES-1; there is no wrap-around.

Optional Feature:
- Macro: ENTRADA_SENSOR_CHECK_EN.
- Defined:
  - A commit that would leave sw_out[IDX_ABERTO] and sw_out[IDX_FECHADO] both 1 is blocked for the bit rising to 1.
  - That bit's counter holds at DEBOUNCE_CYCLES-1, no changed pulse is issued, and erro_sensor=1 while blocked.
  - When the conflict resolves, either sync bit returning or the other sensor committing to 0, erro_sensor <= 0. The blocked bit then commits on the next edge if it still differs.
  - If both sensors would rise in the same cycle, both are blocked.
  - Commits to 0 are never blocked.
- Undefined: no check; erro_sensor is tied to 0 (the port is always present).

Test Plan:
- Reset / defaults (DEBOUNCE_CYCLES=4): hold reset_n=0 with sw_in=5'b11111 -> sw_out=0, changed=0, quieto=1, erro_sensor=0. Release reset_n -> sw_out=5'b11111 exactly 6 edges after release, changed=5'b11111 for one cycle.
- Clean step: sw_in 00000 -> 10110 -> sw_out=10110 on the 6th edge; changed=10110 for one cycle; quieto=0 during edges 3..5, else 1.
- Glitch rejection: pulse sw_in[4] high for 3 synchronized cycles, then low -> sw_out stays 0, changed stays 0, counter returns to 0.
- Bounce: sw_in[0] high 2 cycles, low 1, high thereafter -> sw_out[0] rises 4 edges after the final stable high reaches sync2, never earlier.
- Async reset mid-count: assert reset_n=0 between clock edges at cnt=2 -> sw_out, changed and counters clear immediately; no commit after release until a full 2+4 cycles elapse.
- With ENTRADA_SENSOR_CHECK_EN: sw_out aberto=1 established, then raise fechado -> sw_out[2] stays 0, erro_sensor=1. Drop aberto -> after 6 edges aberto commits 0, erro_sensor=0, fechado commits 1 on the next edge. Without the macro: both reach 1 and erro_sensor stays 0.
